cluster_truncator: RTL

//  Parametrised successor cluster-truncation stage. Latches a WIDTH-bit s-bit/VPF word once per frame, then clears
//  the least-significant set bit each clock (a & ~(-a) per segment, prefix-OR gated across segments), so a pipelined

---
 rtl/cluster_truncator_pkg.sv | 19 +
 rtl/cluster_truncator_segment.sv | 35 +++
 rtl/cluster_truncator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cluster_truncator_pkg.sv
// Shared constants, types and helpers for the cluster truncation stage.
package cluster_truncator_pkg;

    localparam int unsigned DefWidth  = 1536;
    localparam int unsigned DefMxsegs = 24;
    localparam int unsigned DefPasses = 8;

    // Frame-phase tracker: idle until a frame_clock rise, then count to the latch phase.
    typedef enum logic [0:0] {
        PhIdle,
        PhCount
    } phase_state_e;

    // Width of the pass counter; at least one bit even for a single-pass frame.
    function automatic int unsigned pass_width(input int unsigned passes);
        return (passes > 1) ? $clog2(passes) : 1;
    endfunction

endpackage

// File: rtl/cluster_truncator_segment.sv
// One segment of the truncation register: loads a fresh slice or clears its own LSB
// unless a lower segment still holds set bits.
module cluster_truncator_segment #(
    parameter int unsigned SEGSIZE = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               keep,
    input  logic [SEGSIZE-1:0] din,
    output logic [SEGSIZE-1:0] seg,
    output logic               active
);

    logic [SEGSIZE-1:0] seg_q;
    logic [SEGSIZE-1:0] neg_seg;

    // Two's complement of the slice; seg & ~(-seg) drops the lowest set bit.
    assign neg_seg = SEGSIZE'(0) - seg_q;

    // Segment register: reset, load a new word, hold, or clear the lowest set bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q <= '0;
        end else if (load) begin
            seg_q <= din;
        end else if (!keep) begin
            seg_q <= seg_q & ~neg_seg;
        end
    end

    assign seg    = seg_q;
    assign active = |seg_q;

endmodule

// File: rtl/cluster_truncator.sv
// Cluster truncation stage: latches a cluster word once per frame, then removes the
// globally lowest set bit every clock so a downstream encoder sees a new LSB each pass.
module cluster_truncator
    import cluster_truncator_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned MXSEGS      = DefMxsegs,
    parameter int unsigned PASSES      = DefPasses,
    parameter int unsigned PASS_W      = pass_width(PASSES),
    parameter bit          FRAME_MODE  = 1'b1,
    parameter int unsigned LATCH_PHASE = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_clock,
    input  logic              latch_strobe,
    input  logic [WIDTH-1:0]  vpfs_in,
    output logic [WIDTH-1:0]  vpfs_out,
    output logic [PASS_W-1:0] pass,
    output logic              empty,
    output logic              overflow
);

    localparam int unsigned       SEGSIZE   = WIDTH / MXSEGS;
    localparam logic [PASS_W-1:0] PassMax   = PASS_W'(PASSES - 1);
    localparam logic [PASS_W-1:0] PhaseLast = PASS_W'(LATCH_PHASE);

    if (WIDTH % MXSEGS != 0) begin : g_bad_width
        $error("cluster_truncator: WIDTH must be a multiple of MXSEGS");
    end
    if (FRAME_MODE && (LATCH_PHASE + 2 > PASSES)) begin : g_bad_phase
        $error("cluster_truncator: LATCH_PHASE must be in 0..PASSES-2");
    end

    logic [1:0]        fc_hist_q;
    logic              fc_rise;
    phase_state_e      ph_state_q, ph_state_d;
    logic [PASS_W-1:0] phase_q, phase_d;
    logic              frame_req;
    logic              latch_req;
    logic [MXSEGS-1:0] latch_en_q;
    logic [MXSEGS-1:0] active;
    logic [MXSEGS-1:0] keep;
    logic [PASS_W-1:0] pass_q;
    logic              overflow_q;

    assign fc_rise = fc_hist_q[0] & ~fc_hist_q[1];

    // Frame sampler, phase tracker and replicated latch enable (one copy per segment).
    always_ff @(posedge clock) begin
        if (reset) begin
            fc_hist_q  <= '0;
            ph_state_q <= PhIdle;
            phase_q    <= '0;
            latch_en_q <= '0;
        end else begin
            fc_hist_q  <= {fc_hist_q[0], frame_clock};
            ph_state_q <= ph_state_d;
            phase_q    <= phase_d;
            latch_en_q <= {MXSEGS{latch_req}};
        end
    end

    // Raise the frame latch request LATCH_PHASE cycles after a detected rise.
    always_comb begin
        ph_state_d = ph_state_q;
        phase_d    = phase_q;
        frame_req  = 1'b0;
        case (ph_state_q)
            PhIdle: begin
                if (fc_rise) begin
                    if (LATCH_PHASE == 0) begin
                        frame_req = 1'b1;
                    end else begin
                        ph_state_d = PhCount;
                        phase_d    = PASS_W'(1);
                    end
                end
            end
            PhCount: begin
                if (phase_q == PhaseLast) begin
                    frame_req  = 1'b1;
                    ph_state_d = PhIdle;
                    phase_d    = '0;
                end else begin
                    phase_d = phase_q + PASS_W'(1);
                end
            end
            default: begin
                ph_state_d = PhIdle;
                phase_d    = '0;
            end
        endcase
    end

    assign latch_req = FRAME_MODE ? frame_req : latch_strobe;

    // Prefix-OR: a segment holds whenever any lower segment still has a set bit.
    always_comb begin
        keep = '0;
        for (int i = 1; i < MXSEGS; i++) begin
            keep[i] = keep[i-1] | active[i-1];
        end
    end

    for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
        cluster_truncator_segment #(
            .SEGSIZE(SEGSIZE)
        ) u_seg (
            .clock  (clock),
            .reset  (reset),
            .load   (latch_en_q[g]),
            .keep   (keep[g]),
            .din    (vpfs_in[g*SEGSIZE +: SEGSIZE]),
            .seg    (vpfs_out[g*SEGSIZE +: SEGSIZE]),
            .active (active[g])
        );
    end

    // Pass counter saturates; overflow flags set bits thrown away by a reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            pass_q     <= '0;
            overflow_q <= 1'b0;
        end else if (latch_en_q[0]) begin
            pass_q     <= '0;
            overflow_q <= |vpfs_out;
        end else begin
            overflow_q <= 1'b0;
            if (pass_q != PassMax) begin
                pass_q <= pass_q + PASS_W'(1);
            end
        end
    end

    assign pass     = pass_q;
    assign overflow = overflow_q;
    assign empty    = ~|vpfs_out;

endmodule
